lcd_spi_serialiser: RTL and testbench
=====================================

// Module: lcd_spi_serialiser
// PURPOSE
// - Mode-0 SPI transmitter driving the SPI LCD pins (lcd_cs, lcd_dc, lcd_sck, lcd_mosi).
// - Sits downstream of the display pixel/command source in riscboy_core.
// - Accepts 8- or 16-bit words on a valid/ready stream and shifts each out MSB-first.
// - Handles chip-select framing and D/C per word; back-to-back words stream without gaps.
// PARAMETERS
// - W_DIV  8  width of clkdiv input (SCK half-period, in clk cycles)
// PORTS
// - clk       in   1       system clock; all logic on posedge
// - rst       in   1       asynchronous, active-high reset
// - clkdiv    in   W_DIV   SCK half-period in clk cycles; 0 treated as 1
// - in_data   in   16      word to send; 8-bit words use in_data[7:0]
// - in_size   in   1       0 = 8-bit word, 1 = 16-bit word
// - in_dc     in   1       D/C level for this word (1 = data/pixel, 0 = command)
// - in_valid  in   1       source has a word
// - in_ready  out  1       serialiser accepts; transfer on in_valid && in_ready at posedge
// - busy      out  1       1 in any state other than IDLE
// - lcd_cs    out  1       chip select, active low (1 = deselected)
// - lcd_dc    out  1       D/C pin, stable for the whole word
// - lcd_sck   out  1       SPI clock, idles low
// - lcd_mosi  out  1       SPI data; changes only while lcd_sck is low
// BEHAVIOUR
// - Reset (async, immediate): lcd_cs=1, lcd_sck=0, lcd_mosi=0, lcd_dc=0, in_ready=0, busy=0, state=IDLE.
//   - A partial word is dropped.
//   - in_ready rises on the first clk edge after rst falls.
// - clkdiv (C, 0→1), in_size and in_dc are latched at word accept; later changes affect only later words.
// - Divider counter counts C cycles per phase; all outputs are registered.
// - States:
//   - IDLE:  in_ready=1, cs=1. On accept: load shift reg, bit count (8/16), dc; go SETUP.
//   - SETUP: cs=0, sck=0, mosi=MSB, for C cycles; go HIGH.
//   - HIGH:  sck=1 for C cycles (slave samples on the rising edge). At end: sck=0.
//            - Bits remain: shift, mosi=next bit, go LOW.
//            - Last bit, in_valid=1: accept the new word (in_ready=1 on exactly this cycle), mosi=new MSB,
//              dc=new in_dc, go LOW.
//            - Last bit, in_valid=0: go HOLD.
//   - LOW:   sck=0 for C cycles; go HIGH.
//   - HOLD:  sck=0, cs=0 for C cycles; then cs=1, go GAP.
//   - GAP:   cs=1 for C cycles (min deselect time); go IDLE.
// - in_ready is 0 in all states except IDLE and the final HIGH cycle of a word's last bit.
// - Timing, isolated N-bit word:
//   - cs low for (1+2N)·C cycles.
//   - first sck rise C cycles after cs falls.
//   - next accept ≥ C cycles after cs rises.
// - Back-to-back words: cs stays low and sck period stays 2C with no stretch; word boundary is invisible except for dc.
// - mosi holds the last-sent bit in HOLD/GAP/IDLE; lcd_dc holds its last value.
// - Simultaneous in_valid with the final HIGH cycle takes the back-to-back path.
//   - The next word is never dropped and never delayed into HOLD.
// TESTING
// 1. C=1, 16-bit 0xF81F, dc=1 → 16 sck rises; sampled bits = F81F; cs low 33 cycles; busy 34 cycles.
// 2. C=3, 8-bit cmd 0x2C dc=0, then 16-bit 0x07E0 dc=1 held valid →
//    - 24 rises; cs low continuously 147 cycles.
//    - dc flips 0→1 while sck low before the 9th rise.
//    - bytes 2C, 07E0 captured.
// 3. C=0 → behaves identically to C=1 (cycle-exact compare against scenario 1).
// 4. Two isolated 8-bit words 0xA5, 0x5A → cs high ≥1·C cycles between frames;
//    - LCD monitor shift count resets; only the data word is captured when dc=1.
// 5. Assert rst mid-word (after 5 rises) →
//    - same cycle: cs=1, sck=0, in_ready=0.
//    - after release: next word 0x1234 sent cleanly and captured.
// 6. clkdiv changed 2→5 mid-word → current word keeps 4-cycle sck period; next word uses 10.

Source files
------------

// File: rtl/lcd_spi_serialiser.sv
// lcd_spi_serialiser: mode-0 SPI transmitter for the LCD, 8/16-bit words with CS framing and per-word D/C
module lcd_spi_serialiser #(
    parameter int W_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W_DIV-1:0] clkdiv,
    input  logic [15:0]      in_data,
    input  logic             in_size,
    input  logic             in_dc,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             lcd_cs,
    output logic             lcd_dc,
    output logic             lcd_sck,
    output logic             lcd_mosi
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
    state_t           state;
    logic [W_DIV-1:0] cnt, cdiv, c_in;
    logic [14:0]      sr;
    logic [4:0]       bits;
    logic             done, last, acc;
    always_comb begin
        c_in = clkdiv == '0 ? W_DIV'(1) : clkdiv;
        done = cnt == '0;
        last = bits == 5'd1;
        acc  = in_valid && in_ready;
    end
    // sr holds the bits still to be sent after the one currently on lcd_mosi
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cdiv     <= W_DIV'(1);
            sr       <= '0;
            bits     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            lcd_cs   <= 1'b1;
            lcd_dc   <= 1'b0;
            lcd_sck  <= 1'b0;
            lcd_mosi <= 1'b0;
        end else begin
            cnt <= cnt - W_DIV'(1);
            case (state)
                IDLE: in_ready <= 1'b1;
                SETUP, LOW: if (done) begin
                    state    <= HIGH;
                    cnt      <= cdiv - W_DIV'(1);
                    lcd_sck  <= 1'b1;
                    in_ready <= cdiv == W_DIV'(1) && last;
                end
                HIGH: if (!done) begin
                    in_ready <= cnt == W_DIV'(1) && last;
                end else begin
                    lcd_sck  <= 1'b0;
                    in_ready <= 1'b0;
                    cnt      <= cdiv - W_DIV'(1);
                    state    <= last ? HOLD : LOW;
                    if (!last) begin
                        sr       <= {sr[13:0], 1'b0};
                        lcd_mosi <= sr[14];
                        bits     <= bits - 5'd1;
                    end
                end
                HOLD: if (done) begin
                    state  <= GAP;
                    cnt    <= cdiv - W_DIV'(1);
                    lcd_cs <= 1'b1;
                end
                GAP: if (done) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // an accept in the last HIGH cycle overrides HOLD and streams straight into LOW
            if (acc) begin
                state    <= state == IDLE ? SETUP : LOW;
                cnt      <= c_in - W_DIV'(1);
                cdiv     <= c_in;
                sr       <= in_size ? in_data[14:0] : {in_data[6:0], 8'h00};
                bits     <= in_size ? 5'd16 : 5'd8;
                lcd_mosi <= in_size ? in_data[15] : in_data[7];
                lcd_dc   <= in_dc;
                lcd_cs   <= 1'b0;
                in_ready <= 1'b0;
                busy     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_spi_serialiser.sv
// tb_lcd_spi_serialiser: scoreboard bench with an LCD-side monitor capturing words on sck rises
module tb_lcd_spi_serialiser;
    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  clkdiv = 8'd1;
    logic [15:0] in_data = '0;
    logic        in_size = 1'b0, in_dc = 1'b0, in_valid = 1'b0;
    logic        in_ready, busy, lcd_cs, lcd_dc, lcd_sck, lcd_mosi;

    lcd_spi_serialiser #(.W_DIV(8)) dut (
        .clk(clk), .rst(rst), .clkdiv(clkdiv), .in_data(in_data), .in_size(in_size),
        .in_dc(in_dc), .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
        .lcd_cs(lcd_cs), .lcd_dc(lcd_dc), .lcd_sck(lcd_sck), .lcd_mosi(lcd_mosi)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] d; logic dc; logic sz;} w_t;
    w_t exp_q[$];
    int checks = 0, errors = 0;
    int acc_n = 0, gi = 0;
    logic size_a[64];

    int cyc = 0, cs_low_n = 0, busy_n = 0, rise_n = 0, fall_n = 0, drop_n = 0, got_n = 0;
    int gap = 0, bad_dc = 0, bad_mosi = 0, nb = 0, prt = -1, cs_hi_t = 0;
    int per_a[512];
    logic dc_a[512];
    logic [15:0] got_d[64];
    logic got_dc[64];
    logic [15:0] sh = '0;
    logic pcs = 1'b1, psck = 1'b0, pdc = 1'b0, pmosi = 1'b0;

    // LCD-side monitor: samples on the falling clk edge, away from DUT updates
    always @(negedge clk) begin
        cyc++;
        if (!lcd_cs) cs_low_n++;
        if (busy) busy_n++;
        if (lcd_cs && !pcs) begin
            cs_hi_t = cyc;
            if (nb != 0) drop_n++;
            nb = 0;
        end
        if (!lcd_cs && pcs) begin
            fall_n++;
            gap = cyc - cs_hi_t;
            prt = -1;
        end
        if (lcd_sck && !psck && rise_n < 511) begin
            rise_n++;
            per_a[rise_n] = prt < 0 ? 0 : cyc - prt;
            prt = cyc;
            dc_a[rise_n] = lcd_dc;
            sh = {sh[14:0], lcd_mosi};
            nb++;
            if (nb == (size_a[(got_n + drop_n) % 64] ? 16 : 8)) begin
                got_d[got_n % 64]  = size_a[(got_n + drop_n) % 64] ? sh : {8'h00, sh[7:0]};
                got_dc[got_n % 64] = lcd_dc;
                got_n++;
                nb = 0;
            end
        end
        if (lcd_sck && lcd_dc != pdc) bad_dc++;
        if (lcd_sck && lcd_mosi != pmosi) bad_mosi++;
        pcs = lcd_cs;
        psck = lcd_sck;
        pdc = lcd_dc;
        pmosi = lcd_mosi;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic sz, input logic dc);
        int t = 0;
        in_data = d;
        in_size = sz;
        in_dc = dc;
        in_valid = 1'b1;
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("accept_timeout", int'(in_ready), 1);
        if (in_ready) begin
            size_a[acc_n % 64] = sz;
            acc_n++;
            exp_q.push_back({d, dc, sz});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || !in_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", int'(t < 3000), 1);
    endtask

    task automatic score();
        w_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (gi >= got_n) chk("word_missing", gi, got_n + 1);
            else begin
                chk("word_data", got_d[gi % 64], e.sz ? e.d : {8'h00, e.d[7:0]});
                chk("word_dc", got_dc[gi % 64], e.dc);
                gi++;
            end
        end
        chk("word_extra", got_n, gi);
    endtask

    task automatic chk_per(input string tag, input int r_from, input int r_to, input int exp);
        int bad = 0;
        for (int i = r_from; i <= r_to; i++) if (per_a[i] != exp) bad++;
        chk(tag, bad, 0);
    endtask

    task automatic wait_rises(input int r0, input int n);
        int t = 0;
        while (rise_n - r0 < n && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("rise_timeout", int'(rise_n - r0 >= n), 1);
    endtask

    task automatic single_16(input string tag, input logic [7:0] div);
        int r0, c0, b0, f0;
        clkdiv = div;
        r0 = rise_n; c0 = cs_low_n; b0 = busy_n; f0 = fall_n;
        send(16'hF81F, 1'b1, 1'b1);
        wait_idle();
        chk({tag, "_rises"}, rise_n - r0, 16);
        chk({tag, "_cs_low"}, cs_low_n - c0, 33);
        chk({tag, "_busy"}, busy_n - b0, 34);
        chk({tag, "_frames"}, fall_n - f0, 1);
        chk_per({tag, "_period"}, r0 + 2, r0 + 16, 2);
        score();
    endtask

    initial begin
        int r0, c0, b0, f0, d0, bd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs", lcd_cs, 1);
        chk("rst_sck", lcd_sck, 0);
        chk("rst_mosi", lcd_mosi, 0);
        chk("rst_dc", lcd_dc, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        single_16("s1", 8'd1);

        clkdiv = 8'd3;
        r0 = rise_n; c0 = cs_low_n; b0 = busy_n; f0 = fall_n; bd0 = bad_dc;
        send(16'hFF2C, 1'b0, 1'b0);
        send(16'h07E0, 1'b1, 1'b1);
        wait_idle();
        chk("s2_rises", rise_n - r0, 24);
        chk("s2_cs_low", cs_low_n - c0, 147);
        chk("s2_busy", busy_n - b0, 150);
        chk("s2_frames", fall_n - f0, 1);
        chk_per("s2_period", r0 + 2, r0 + 24, 6);
        chk("s2_dc_rise8", dc_a[r0 + 8], 0);
        chk("s2_dc_rise9", dc_a[r0 + 9], 1);
        chk("s2_dc_sck_hi", bad_dc - bd0, 0);
        score();

        single_16("s3", 8'd0);

        clkdiv = 8'd2;
        r0 = rise_n; c0 = cs_low_n; f0 = fall_n;
        send(16'h00A5, 1'b0, 1'b1);
        wait_idle();
        send(16'h005A, 1'b0, 1'b1);
        wait_idle();
        chk("s4_frames", fall_n - f0, 2);
        chk("s4_gap_ge_c", int'(gap >= 2), 1);
        chk("s4_cs_low", cs_low_n - c0, 68);
        chk("s4_rises", rise_n - r0, 16);
        score();

        clkdiv = 8'd1;
        r0 = rise_n; d0 = drop_n;
        send(16'hBEEF, 1'b1, 1'b1);
        wait_rises(r0, 5);
        rst = 1'b1;
        #1;
        chk("s5_cs", lcd_cs, 1);
        chk("s5_sck", lcd_sck, 0);
        chk("s5_ready", in_ready, 0);
        chk("s5_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("s5_drop", drop_n - d0, 1);
        chk("s5_ready_up", in_ready, 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        send(16'h1234, 1'b1, 1'b0);
        wait_idle();
        score();

        clkdiv = 8'd2;
        r0 = rise_n; c0 = cs_low_n;
        send(16'h00C3, 1'b0, 1'b1);
        wait_rises(r0, 3);
        clkdiv = 8'd5;
        wait_idle();
        send(16'h003C, 1'b0, 1'b0);
        wait_idle();
        chk_per("s6_period_old", r0 + 2, r0 + 8, 4);
        chk_per("s6_period_new", r0 + 10, r0 + 16, 10);
        chk("s6_cs_low", cs_low_n - c0, 119);
        score();

        chk("dc_sck_hi", bad_dc, 0);
        chk("mosi_sck_hi", bad_mosi, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
